// File: rtl/occupancy_pkg.sv
// Shared grid constants and reader FSM state encoding for the occupancy grid
// reader and writer.
package occupancy_pkg;

  localparam int X_WIDTH    = 5;
  localparam int Y_WIDTH    = 4;
  localparam int CELL_WIDTH = 8;
  localparam int ADDR_WIDTH = 9;

  localparam logic [X_WIDTH-1:0] X_MAX = '1;
  localparam logic [Y_WIDTH-1:0] Y_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD0  = 3'd1,
    ST_RD1  = 3'd2,
    ST_RD2  = 3'd3,
    ST_RD3  = 3'd4,
    ST_WAIT = 3'd5,
    ST_OUT  = 3'd6
  } rd_state_t;

endpackage

// File: rtl/index_to_address.sv
// Maps a grid cell index (x, y) to its grid RAM address, row-major with
// 32 cells per row.
module index_to_address
  import occupancy_pkg::*;
(
  input  logic [X_WIDTH-1:0]    x,
  input  logic [Y_WIDTH-1:0]    y,
  output logic [ADDR_WIDTH-1:0] addr
);

  assign addr = {y, x};

endmodule

// File: rtl/occupancy_neighbor_reader.sv
// Reads the 2x2 neighbourhood (x,y)..(x+1,y+1) of a grid cell from a
// one-cycle-latency RAM. Define OCCUPANCY_EDGE_CLAMP_EN to clamp neighbours
// past the grid edge instead of returning zero for them.
module occupancy_neighbor_reader
  import occupancy_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  q_valid,
  output logic                  q_ready,
  input  logic [4:0]            q_x,
  input  logic [3:0]            q_y,
  output logic                  mem_rd_en,
  output logic [8:0]            mem_address,
  input  logic [7:0]            mem_rd_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [7:0]            res_c00,
  output logic [7:0]            res_c10,
  output logic [7:0]            res_c01,
  output logic [7:0]            res_c11,
  output logic [2:0]            dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // q_ready is high only in IDLE; res_valid is high only in OUT and the
  // result registers do not change while it is high.

  rd_state_t               state_q, state_d;
  logic [X_WIDTH-1:0]      x_q, x_d;
  logic [Y_WIDTH-1:0]      y_q, y_d;
  logic [CELL_WIDTH-1:0]   c00_q, c00_d, c10_q, c10_d, c01_q, c01_d, c11_q, c11_d;

  logic [X_WIDTH-1:0]      nx;
  logic [Y_WIDTH-1:0]      ny;
  logic                    oob_x, oob_y;
  logic [X_WIDTH-1:0]      idx_x;
  logic [Y_WIDTH-1:0]      idx_y;
  logic [ADDR_WIDTH-1:0]   idx_addr;
  logic                    rd_en;

`ifdef OCCUPANCY_EDGE_CLAMP_EN
  assign nx    = (x_q == X_MAX) ? x_q : x_q + 1'b1;
  assign ny    = (y_q == Y_MAX) ? y_q : y_q + 1'b1;
  assign oob_x = 1'b0;
  assign oob_y = 1'b0;
`else
  // The wrapped nx/ny never reach the RAM: oob_* suppresses the read.
  assign nx    = x_q + 1'b1;
  assign ny    = y_q + 1'b1;
  assign oob_x = (x_q == X_MAX);
  assign oob_y = (y_q == Y_MAX);
`endif

  index_to_address u_index_to_address (
    .x    (idx_x),
    .y    (idx_y),
    .addr (idx_addr)
  );

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    c00_d     = c00_q;
    c10_d     = c10_q;
    c01_d     = c01_q;
    c11_d     = c11_q;
    idx_x     = x_q;
    idx_y     = y_q;
    rd_en     = 1'b0;
    q_ready   = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        q_ready = 1'b1;
        if (q_valid) begin
          x_d     = q_x;
          y_d     = q_y;
          state_d = ST_RD0;
        end
      end
      ST_RD0: begin
        rd_en   = 1'b1;
        state_d = ST_RD1;
      end
      // Each RD state also captures the data of the read issued one state earlier.
      ST_RD1: begin
        idx_x   = nx;
        rd_en   = !oob_x;
        c00_d   = mem_rd_data;
        state_d = ST_RD2;
      end
      ST_RD2: begin
        idx_y   = ny;
        rd_en   = !oob_y;
        c10_d   = oob_x ? '0 : mem_rd_data;
        state_d = ST_RD3;
      end
      ST_RD3: begin
        idx_x   = nx;
        idx_y   = ny;
        rd_en   = !(oob_x || oob_y);
        c01_d   = oob_y ? '0 : mem_rd_data;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        c11_d   = (oob_x || oob_y) ? '0 : mem_rd_data;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        res_valid = 1'b1;
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      c00_q   <= '0;
      c10_q   <= '0;
      c01_q   <= '0;
      c11_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      c00_q   <= c00_d;
      c10_q   <= c10_d;
      c01_q   <= c01_d;
      c11_q   <= c11_d;
    end
  end

  assign mem_rd_en   = rd_en;
  assign mem_address = rd_en ? idx_addr : '0;
  assign res_c00     = c00_q;
  assign res_c10     = c10_q;
  assign res_c01     = c01_q;
  assign res_c11     = c11_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_occupancy_neighbor_reader.sv
// Bench for occupancy_neighbor_reader: directed queries against a RAM model
// holding cell(a) = a[7:0], with expected neighbourhoods checked by a monitor.
module tb_occupancy_neighbor_reader;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       q_valid;
  logic       q_ready;
  logic [4:0] q_x;
  logic [3:0] q_y;
  logic       mem_rd_en;
  logic [8:0] mem_address;
  logic [7:0] mem_rd_data = 8'd0;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_c00, res_c10, res_c01, res_c11;
  logic [2:0] dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int n_reads = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];
  int          acc_q[$];
  logic [31:0] mon_exp;

  occupancy_neighbor_reader dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .q_valid     (q_valid),
    .q_ready     (q_ready),
    .q_x         (q_x),
    .q_y         (q_y),
    .mem_rd_en   (mem_rd_en),
    .mem_address (mem_address),
    .mem_rd_data (mem_rd_data),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_c00     (res_c00),
    .res_c10     (res_c10),
    .res_c01     (res_c01),
    .res_c11     (res_c11),
    .dbg_state   (dbg_state)
  );

  // clock / reset block
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // grid RAM model, one cycle read latency
  always @(posedge clock) begin
    if (mem_rd_en) begin
      mem_rd_data <= mem_address[7:0];
      n_reads     <= n_reads + 1;
    end
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h) at cycle %0d", nm, act, act, exp, exp, cyc);
    end
  endfunction

  // expected read strobe/address for neighbour k (0:00 1:10 2:01 3:11)
  function automatic void exp_rd(input int x, input int y, input int k,
                                 output logic en, output logic [8:0] a);
    int nx, ny;
    nx = (k == 1 || k == 3) ? x + 1 : x;
    ny = (k >= 2) ? y + 1 : y;
`ifdef OCCUPANCY_EDGE_CLAMP_EN
    if (nx > 31) nx = 31;
    if (ny > 15) ny = 15;
    en = 1'b1;
`else
    en = (nx <= 31) && (ny <= 15);
`endif
    a = en ? 9'(ny * 32 + nx) : 9'd0;
  endfunction

  // result monitor / scoreboard
  always begin
    @(negedge clock);
    #2;
    if (reset_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: got 0x%h, expected no result", {res_c00, res_c10, res_c01, res_c11});
      end else begin
        mon_exp = exp_q.pop_front();
        chk("result", {res_c00, res_c10, res_c01, res_c11}, mon_exp);
      end
    end
  end

  // accept monitor
  always begin
    @(negedge clock);
    #2;
    if (reset_n && q_valid && q_ready) acc_q.push_back(cyc);
  end

  task automatic do_query(input int x, input int y, input logic [31:0] exp_res, input int stall);
    int waited;
    int r0;
    int n_en;
    logic en;
    logic [8:0] a;
    waited = 0;
    n_en = 0;
    @(negedge clock);
    while (!q_ready && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    if (!q_ready) begin
      chk("q_ready_timeout", 32'(q_ready), 32'd1);
      return;
    end
    q_x = 5'(x);
    q_y = 4'(y);
    q_valid = 1'b1;
    res_ready = (stall > 0) ? 1'b0 : 1'b1;
    exp_q.push_back(exp_res);
    r0 = n_reads;
    @(negedge clock);
    q_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clock);
      exp_rd(x, y, k, en, a);
      if (en) n_en++;
      chk("rd_en", 32'(mem_rd_en), 32'(en));
      chk("rd_addr", 32'(mem_address), 32'(a));
    end
    @(negedge clock);
    chk("res_valid_wait", 32'(res_valid), 32'd0);
    @(negedge clock);
    chk("res_valid_latency", 32'(res_valid), 32'd1);
    chk("ram_read_count", 32'(n_reads - r0), 32'(n_en));
    if (stall > 0) begin
      q_x = 5'd7;
      q_y = 4'd7;
      q_valid = 1'b1;
      for (int s = 0; s < stall; s++) begin
        @(negedge clock);
        chk("stall_res_valid", 32'(res_valid), 32'd1);
        chk("stall_q_ready", 32'(q_ready), 32'd0);
        chk("stall_results", {res_c00, res_c10, res_c01, res_c11}, exp_res);
        chk("stall_state", 32'(dbg_state), 32'd6);
      end
      q_valid = 1'b0;
      res_ready = 1'b1;
    end
  endtask

  initial begin
    logic seen;
    reset_n = 1'b0;
    q_valid = 1'b0;
    q_x = '0;
    q_y = '0;
    res_ready = 1'b0;

    repeat (3) @(negedge clock);
    chk("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_mem_address", 32'(mem_address), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_results", {res_c00, res_c10, res_c01, res_c11}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_q_ready", 32'(q_ready), 32'd1);
    chk("rst_state", 32'(dbg_state), 32'd0);

    // interior and edge neighbourhoods
    do_query(3, 2, {8'd67, 8'd68, 8'd99, 8'd100}, 0);
    do_query(30, 14, {8'd222, 8'd223, 8'd254, 8'd255}, 0);
`ifdef OCCUPANCY_EDGE_CLAMP_EN
    do_query(31, 5, {8'd191, 8'd191, 8'd223, 8'd223}, 0);
    do_query(31, 15, {8'd255, 8'd255, 8'd255, 8'd255}, 0);
    do_query(0, 15, {8'd224, 8'd225, 8'd224, 8'd225}, 0);
`else
    do_query(31, 5, {8'd191, 8'd0, 8'd223, 8'd0}, 0);
    do_query(31, 15, {8'd255, 8'd0, 8'd0, 8'd0}, 0);
    do_query(0, 15, {8'd224, 8'd225, 8'd0, 8'd0}, 0);
`endif

    // consumer back-pressure in OUT
    do_query(3, 2, {8'd67, 8'd68, 8'd99, 8'd100}, 10);

    // reset during RD2 aborts the query
    @(negedge clock);
    while (!q_ready) @(negedge clock);
    q_x = 5'd10;
    q_y = 4'd3;
    q_valid = 1'b1;
    @(negedge clock);
    q_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("abort_rd2_en", 32'(mem_rd_en), 32'd1);
    chk("abort_rd2_addr", 32'(mem_address), 32'd138);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_rd_en_drop", 32'(mem_rd_en), 32'd0);
    chk("abort_addr_zero", 32'(mem_address), 32'd0);
    chk("abort_state", 32'(dbg_state), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      seen = seen | res_valid;
    end
    chk("abort_no_result", 32'(seen), 32'd0);
    chk("abort_results_clear", {res_c00, res_c10, res_c01, res_c11}, 32'd0);
    do_query(0, 0, {8'd0, 8'd1, 8'd32, 8'd33}, 0);

    // back-to-back throughput
    acc_q.delete();
    do_query(5, 7, {8'd229, 8'd230, 8'd5, 8'd6}, 0);
    do_query(1, 1, {8'd33, 8'd34, 8'd65, 8'd66}, 0);
    do_query(20, 9, {8'd52, 8'd53, 8'd84, 8'd85}, 0);
    @(negedge clock);
    chk("b2b_accept_count", 32'(acc_q.size()), 32'd3);
    if (acc_q.size() == 3) begin
      chk("b2b_spacing_1", 32'(acc_q[1] - acc_q[0]), 32'd7);
      chk("b2b_spacing_2", 32'(acc_q[2] - acc_q[1]), 32'd7);
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clock);
    #3;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d vectors, %0d miscompares", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/occupancy_neighbor_reader.md
OCCUPANCY_NEIGHBOR_READER -- requirements
Module: occupancy_neighbor_reader

Interface
REQ-001 SHALL have port clock, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port q_valid, input, 1, query request.
REQ-004 SHALL have port q_ready, output, 1, reader can accept a query.
REQ-005 SHALL have ports q_x and q_y, input, 5 and 4, query cell index.
REQ-006 SHALL have port mem_rd_en, output, 1, read strobe to grid RAM.
REQ-007 SHALL have port mem_address, output, 9, grid RAM address = {y,x} (y*32+x).
REQ-008 SHALL have port mem_rd_data, input, 8, RAM data, valid one cycle after address/strobe.
REQ-009 SHALL have port res_valid, output, 1, result available.
REQ-010 SHALL have port res_ready, input, 1, consumer accepts result.
REQ-011 SHALL have ports res_c00, res_c10, res_c01, res_c11, output, 8 each, cells (x,y), (x+1,y), (x,y+1), (x+1,y+1).

Function
REQ-012 SHALL implement FSM IDLE -> RD0 -> RD1 -> RD2 -> RD3 -> WAIT -> OUT -> IDLE.
REQ-013 SHALL assert q_ready only in IDLE; a query is accepted on an edge with q_valid && q_ready, latching q_x/q_y.
REQ-014 In RD0..RD3 SHALL assert mem_rd_en with mem_address for neighbor 00, 10, 01, 11 respectively; mem_rd_en=0 in all other states.
REQ-015 SHALL capture mem_rd_data into the matching result register on the edge one cycle after that neighbor's address was driven (edges leaving RD1, RD2, RD3, WAIT).
REQ-016 SHALL assert res_valid in OUT only, first cycle being 5 edges after query acceptance; results stable while res_valid=1.
REQ-017 SHALL leave OUT for IDLE on the edge where res_ready=1; res_ready ignored outside OUT.
REQ-018 Neighbor index x+1 > 31 or y+1 > 15 is out-of-grid; handling per REQ-024/025; no wrap-around to column 0 or row 0 ever.
REQ-019 Query-to-query throughput SHALL be 7 cycles minimum with res_ready held high.
REQ-020 mem_address SHALL be 0 when mem_rd_en=0.

Reset
REQ-021 reset_n=0 SHALL immediately force IDLE, q_ready=1 after release, res_valid=0, mem_rd_en=0, mem_address=0, all res_* = 0.
REQ-022 Reset mid-read SHALL abort the query with no result emitted; next query starts cleanly.

Configuration
REQ-023 Macro OCCUPANCY_EDGE_CLAMP_EN selects out-of-grid handling.
REQ-024 With OCCUPANCY_EDGE_CLAMP_EN defined: out-of-grid index clamped to 31 (x) / 15 (y), RAM read normally (e.g. x=31 -> c10 equals c00).
REQ-025 Without it: out-of-grid neighbor SHALL still occupy its RD state with mem_rd_en=0, and its result register SHALL be loaded with 8'd0; timing unchanged.

Structure
REQ-026 Grid constants (X_WIDTH=5, Y_WIDTH=4, CELL_WIDTH=8, ADDR_WIDTH=9) and FSM state enum SHALL live in shared package occupancy_pkg, shared with the grid writer.
REQ-027 Index-to-address mapping SHALL reuse existing sub-module index_to_address; no other sub-module.

Verification
REQ-028 RAM preloaded cell(a)=a[7:0]; query (3,2) -> addresses 67,68,99,100 on 4 consecutive cycles; results 67,68,99,100; res_valid 5 cycles after accept.
REQ-029 Query (31,5): clamp build -> c00=c10=191, c01=c11=223; non-clamp build -> c10=c11=0, only 2 RAM reads issued.
REQ-030 Query (31,15): clamp -> all four = 255 (cell 511 low byte); non-clamp -> c00=255, others 0.
REQ-031 res_ready held 0 for 10 cycles in OUT -> results and res_valid stable, q_ready=0; q_valid ignored until release.
REQ-032 reset_n pulsed low during RD2 -> mem_rd_en drops immediately, no res_valid; subsequent query (0,0) returns 0,1,32,33.
REQ-033 Back-to-back queries with res_ready=1 -> accepts spaced exactly 7 cycles apart.
